// File: rtl/sopc_run_ctrl.sv
// Run controller and register-write tracer for the min SOPC: CPU reset sequencing, bounded run, GPR shadows, trace FIFO.
// Optional: define RUN_CTRL_CHANGE_FILTER_EN to push a watched write only when it changes the shadowed value.
module sopc_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 3,
    parameter int unsigned RUN_CYCLES  = 20,
    parameter int unsigned NUM_WATCH   = 4,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CYC_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        cpu_rst_o,
    input  logic                        wb_we_i,
    input  logic [4:0]                  wb_waddr_i,
    input  logic [DATA_W-1:0]           wb_wdata_i,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [4:0]                  trace_addr_o,
    output logic [DATA_W-1:0]           trace_data_o,
    output logic [CYC_W-1:0]            trace_cycle_o,
    output logic [NUM_WATCH*DATA_W-1:0] watch_regs_o,
    output logic [CYC_W-1:0]            cycle_o,
    output logic                        overflow_o,
    output logic                        finish_o
);

    localparam int unsigned PTR_W  = $clog2(TRACE_DEPTH);
    localparam int unsigned PTR_W1 = PTR_W + 1;
    localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned RUN_W  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                             state_q, state_d;
    logic [RST_W-1:0]                   phase_q, phase_d;
    logic [RUN_W-1:0]                   run_cnt_q, run_cnt_d;
    logic [CYC_W-1:0]                   cycle_q, cycle_d;
    logic                               cpu_rst_q, cpu_rst_d;
    logic                               finish_q, finish_d;
    logic                               overflow_q;
    logic [NUM_WATCH-1:0][DATA_W-1:0]   watch_q;

    logic [PTR_W1-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PTR_W1-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [4:0]                         addr_mem [TRACE_DEPTH];
    logic [DATA_W-1:0]                  data_mem [TRACE_DEPTH];
    logic [CYC_W-1:0]                   cyc_mem  [TRACE_DEPTH];

    logic wb_hit, push_req, push, pop, drop;
    logic fifo_empty, fifo_full, fifo_empty_nxt;

    // Capture qualification and FIFO handshake
    assign wb_hit     = (state_q == ST_RUN) && wb_we_i && ({1'b0, wb_waddr_i} < 6'(NUM_WATCH));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

`ifdef RUN_CTRL_CHANGE_FILTER_EN
    logic [DATA_W-1:0] shadow_cur;
    always_comb begin
        shadow_cur = '0;
        for (int unsigned i = 0; i < NUM_WATCH; i++) begin
            if (wb_waddr_i == 5'(i)) shadow_cur = watch_q[i];
        end
    end
    assign push_req = wb_hit && (wb_wdata_i != shadow_cur);
`else
    assign push_req = wb_hit;
`endif

    assign pop            = !fifo_empty && trace_ready_i;
    assign push           = push_req && (!fifo_full || pop);
    assign drop           = push_req && fifo_full && !pop;
    assign wr_ptr_d       = wr_ptr_q + PTR_W1'(push);
    assign rd_ptr_d       = rd_ptr_q + PTR_W1'(pop);
    assign fifo_empty_nxt = (wr_ptr_d == rd_ptr_d);

    // Run sequencing: next state and registered-output values
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        run_cnt_d = run_cnt_q;
        cycle_d   = cycle_q;
        case (state_q)
            ST_RESET: begin
                if (phase_q == RST_W'(RST_CYCLES - 1)) state_d = ST_RUN;
                else                                   phase_d = phase_q + RST_W'(1);
            end
            ST_RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + CYC_W'(1);
                if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) state_d   = ST_DRAIN;
                else                                     run_cnt_d = run_cnt_q + RUN_W'(1);
            end
            ST_DRAIN: begin
                if (fifo_empty_nxt) state_d = ST_DONE;
            end
            ST_DONE: ;
            default: state_d = ST_RESET;
        endcase
        cpu_rst_d = (state_d != ST_RUN);
        finish_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            phase_q    <= '0;
            run_cnt_q  <= '0;
            cycle_q    <= '0;
            cpu_rst_q  <= 1'b1;
            finish_q   <= 1'b0;
            overflow_q <= 1'b0;
            watch_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            run_cnt_q  <= run_cnt_d;
            cycle_q    <= cycle_d;
            cpu_rst_q  <= cpu_rst_d;
            finish_q   <= finish_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (drop) overflow_q <= 1'b1;
            // Shadows track every watched write, including dropped and filtered ones
            if (wb_hit) begin
                for (int unsigned i = 0; i < NUM_WATCH; i++) begin
                    if (wb_waddr_i == 5'(i)) watch_q[i] <= wb_wdata_i;
                end
            end
        end
    end

    // Trace storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q[PTR_W-1:0]] <= wb_waddr_i;
            data_mem[wr_ptr_q[PTR_W-1:0]] <= wb_wdata_i;
            cyc_mem[wr_ptr_q[PTR_W-1:0]]  <= cycle_q;
        end
    end

    assign trace_valid_o = !fifo_empty;
    assign trace_addr_o  = addr_mem[rd_ptr_q[PTR_W-1:0]];
    assign trace_data_o  = data_mem[rd_ptr_q[PTR_W-1:0]];
    assign trace_cycle_o = cyc_mem[rd_ptr_q[PTR_W-1:0]];
    assign watch_regs_o  = watch_q;
    assign cycle_o       = cycle_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign overflow_o    = overflow_q;
    assign finish_o      = finish_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl with default parameters; covers RUN_CTRL_CHANGE_FILTER_EN both ways.
module tb_sopc_run_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_rst_o;
    logic         wb_we_i;
    logic [4:0]   wb_waddr_i;
    logic [31:0]  wb_wdata_i;
    logic         trace_valid_o;
    logic         trace_ready_i;
    logic [4:0]   trace_addr_o;
    logic [31:0]  trace_data_o;
    logic [15:0]  trace_cycle_o;
    logic [127:0] watch_regs_o;
    logic [15:0]  cycle_o;
    logic         overflow_o;
    logic         finish_o;

    int n_cmp = 0;
    int n_err = 0;

    sopc_run_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_rst_o     (cpu_rst_o),
        .wb_we_i       (wb_we_i),
        .wb_waddr_i    (wb_waddr_i),
        .wb_wdata_i    (wb_wdata_i),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_addr_o  (trace_addr_o),
        .trace_data_o  (trace_data_o),
        .trace_cycle_o (trace_cycle_o),
        .watch_regs_o  (watch_regs_o),
        .cycle_o       (cycle_o),
        .overflow_o    (overflow_o),
        .finish_o      (finish_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int a, input int d, input int c);
        chk({tag, ".valid"}, 64'(trace_valid_o), 64'(1));
        chk({tag, ".addr"},  64'(trace_addr_o),  64'(a));
        chk({tag, ".data"},  64'(trace_data_o),  64'(d));
        chk({tag, ".cyc"},   64'(trace_cycle_o), 64'(c));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".cpu_rst"}, 64'(cpu_rst_o),     64'(1));
        chk({tag, ".cycle"},   64'(cycle_o),       64'(0));
        chk({tag, ".valid"},   64'(trace_valid_o), 64'(0));
        chk({tag, ".watch_lo"}, watch_regs_o[63:0],   64'(0));
        chk({tag, ".watch_hi"}, watch_regs_o[127:64], 64'(0));
        chk({tag, ".ovf"},     64'(overflow_o),    64'(0));
        chk({tag, ".finish"},  64'(finish_o),      64'(0));
    endtask

    task automatic drive_wr(input logic we, input int a, input int d);
        wb_we_i    = we;
        wb_waddr_i = 5'(a);
        wb_wdata_i = 32'(d);
    endtask

    task automatic wait_finish(input string tag);
        int n = 0;
        while (finish_o !== 1'b1 && n < 6) begin
            step();
            n++;
        end
        chk(tag, 64'(finish_o), 64'(1));
    endtask

    task automatic release_reset(input string tag);
        rst = 1'b0;
        step(); chk({tag, ".e1"}, 64'(cpu_rst_o), 64'(1));
        step(); chk({tag, ".e2"}, 64'(cpu_rst_o), 64'(1));
        step(); chk({tag, ".e3"}, 64'(cpu_rst_o), 64'(0));
        chk({tag, ".cyc0"}, 64'(cycle_o), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        trace_ready_i = 1'b0;
        drive_wr(1'b0, 0, 0);
        step(); step();
        chk_cleared("por");

        // ---- Run 1: reset sequence, single write, non-watched, backpressure, filter ----
        release_reset("rel1");
        chk("r1.valid0", 64'(trace_valid_o), 64'(0));
        drive_wr(1'b1, 7, 32'hDEAD);
        step();                                               // cycle 1
        chk("nowatch.valid", 64'(trace_valid_o), 64'(0));
        chk("nowatch.watch", watch_regs_o[63:0], 64'(0));
        chk("cyc1", 64'(cycle_o), 64'(1));
        drive_wr(1'b0, 0, 0);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("cyc_count", 64'(cycle_o), 64'(c));
        end
        drive_wr(1'b1, 1, 32'h0000_1100);
        trace_ready_i = 1'b1;
        step();                                               // cycle 6
        chk_head("single", 1, 32'h0000_1100, 5);
        chk("single.shadow", 64'(watch_regs_o[63:32]), 64'h1100);
        drive_wr(1'b0, 0, 0);
        step();                                               // cycle 7
        chk("single.popped", 64'(trace_valid_o), 64'(0));

        // ready 1,0,1,0 during pushes at cycles 7..10
        drive_wr(1'b1, 2, 32'hB0); trace_ready_i = 1'b1; step();
        chk_head("bp8", 2, 32'hB0, 7);
        drive_wr(1'b1, 3, 32'hB1); trace_ready_i = 1'b0; step();
        chk_head("bp9_stable", 2, 32'hB0, 7);
        drive_wr(1'b1, 2, 32'hB2); trace_ready_i = 1'b1; step();
        chk_head("bp10", 3, 32'hB1, 8);
        drive_wr(1'b1, 3, 32'hB3); trace_ready_i = 1'b0; step();
        chk_head("bp11_stable", 3, 32'hB1, 8);
        drive_wr(1'b0, 0, 0); trace_ready_i = 1'b1; step();
        chk_head("bp12", 2, 32'hB2, 9);
        step();
        chk_head("bp13", 3, 32'hB3, 10);
        step();                                               // cycle 14
        chk("bp.empty", 64'(trace_valid_o), 64'(0));

        step();                                               // cycle 15
        trace_ready_i = 1'b0;
        drive_wr(1'b1, 2, 5); step();
        drive_wr(1'b1, 2, 5); step();                         // cycle 17
        drive_wr(1'b0, 0, 0);
        chk_head("flt.first", 2, 5, 15);
        trace_ready_i = 1'b1;
        step();                                               // cycle 18
`ifdef RUN_CTRL_CHANGE_FILTER_EN
        chk("flt.second_filtered", 64'(trace_valid_o), 64'(0));
`else
        chk_head("flt.second", 2, 5, 16);
`endif
        step();                                               // cycle 19
        chk("r1.cyc19", 64'(cycle_o), 64'(19));
        chk("r1.cpu_run", 64'(cpu_rst_o), 64'(0));
        chk("r1.empty", 64'(trace_valid_o), 64'(0));
        chk("r1.shadow_lo", watch_regs_o[63:0], 64'h0000_1100_0000_0000);
        chk("r1.shadow_hi", watch_regs_o[127:64], 64'h0000_00B3_0000_0005);
        step();
        chk("r1.drain_halt", 64'(cpu_rst_o), 64'(1));
        wait_finish("r1.finish");
        chk("r1.no_ovf", 64'(overflow_o), 64'(0));

        // ---- Run 2: mid-run reset with entries queued ----
        rst = 1'b1; trace_ready_i = 1'b0;
        step();
        chk_cleared("rst2");
        release_reset("rel2");
        step(); step();                                       // cycle 2
        drive_wr(1'b1, 0, 32'h10); step();
        drive_wr(1'b1, 1, 32'h11); step();
        drive_wr(1'b1, 2, 32'h12); step();                    // cycle 5
        drive_wr(1'b0, 0, 0);
        step(); step(); step();                               // cycle 8
        chk("r2.cyc8", 64'(cycle_o), 64'(8));
        chk_head("r2.head", 0, 32'h10, 2);
        chk("r2.reg0_nonzero", 64'(watch_regs_o[31:0]), 64'h10);
        rst = 1'b1;
        step();
        chk_cleared("midrst");
        release_reset("rel3");

        // ---- Run 3: overflow, drain, finish ----
        for (int i = 0; i < 18; i++) begin
            if (i == 16) chk("ovf.before", 64'(overflow_o), 64'(0));
            if (i == 17) chk("ovf.after",  64'(overflow_o), 64'(1));
            drive_wr(1'b1, i % 4, 32'hA000 + i);
            step();
        end
        drive_wr(1'b0, 0, 0);                                 // cycle 18
        chk("ovf.sticky", 64'(overflow_o), 64'(1));
        chk_head("ovf.head", 0, 32'hA000, 0);
        chk("ovf.shadow_lo", watch_regs_o[63:0],   64'h0000_A011_0000_A010);
        chk("ovf.shadow_hi", watch_regs_o[127:64], 64'h0000_A00F_0000_A00E);
        step(); step();
        chk("r3.drain_halt", 64'(cpu_rst_o), 64'(1));
        trace_ready_i = 1'b1;
        drive_wr(1'b1, 0, 32'hFFFF);                          // ignored outside RUN
        for (int j = 0; j < 16; j++) begin
            chk_head("drain", j % 4, 32'hA000 + j, j);
            step();
        end
        drive_wr(1'b0, 0, 0);
        wait_finish("r3.finish");
        chk("r3.empty", 64'(trace_valid_o), 64'(0));
        chk("r3.wb_ignored", 64'(watch_regs_o[31:0]), 64'hA010);
        step(); step(); step();
        chk("done.finish", 64'(finish_o), 64'(1));
        chk("done.cpu_rst", 64'(cpu_rst_o), 64'(1));
        chk("done.ovf", 64'(overflow_o), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
